shadow_capture_ctrl: RTL

SHADOW_CAPTURE_CTRL -- requirements
Module: shadow_capture_ctrl

---
 rtl/shadow_capture_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/shadow_capture_ctrl.sv
// Shadow-chain capture and readout controller: pulses capture, waits for the
// chain to become ready, then clocks it out bit-serially into WORD_W-bit words.
module shadow_capture_ctrl #(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned DIV    = 2,
  parameter int unsigned WORD_W = 8,
  parameter int unsigned TMO    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              sc_c_en,
  output logic              sc_d_clk,
  output logic              sc_d_in,
  input  logic              sc_d_out,
  input  logic              sc_d_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last
);

  localparam int unsigned DivW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TmoW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam int unsigned PosW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCapture = 3'd1;
  localparam logic [2:0] StWaitRdy = 3'd2;
  localparam logic [2:0] StShiftLo = 3'd3;
  localparam logic [2:0] StHold    = 3'd4;
  localparam logic [2:0] StShiftHi = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PosW-1:0]   pos_q, pos_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [TmoW-1:0]   tmo_q, tmo_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              word_last_q, word_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              sc_c_en_q, sc_c_en_d;
  logic              sc_d_clk_q, sc_d_clk_d;
  logic [LEN_W-1:0]  bit_cnt_inc;

  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    bit_cnt_d    = bit_cnt_q;
    pos_d        = pos_q;
    div_d        = div_q;
    tmo_d        = tmo_q;
    acc_d        = acc_q;
    word_data_d  = word_data_q;
    word_last_d  = word_last_q;
    word_valid_d = word_valid_q & ~word_ready;
    done_d       = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      StIdle: begin
        if (start && (len != '0)) begin
          len_d     = len;
          bit_cnt_d = '0;
          pos_d     = '0;
          acc_d     = '0;
          state_d   = StCapture;
        end
      end
      StCapture: begin
        tmo_d   = '0;
        state_d = StWaitRdy;
      end
      StWaitRdy: begin
        if (sc_d_ready) begin
          div_d   = '0;
          state_d = StShiftLo;
        end else if (tmo_q == TmoW'(TMO - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StShiftLo: begin
        if (div_q == DivW'(DIV - 1)) begin
          div_d        = '0;
          acc_d[pos_q] = sc_d_out;
          bit_cnt_d    = bit_cnt_inc;
          if ((pos_q == PosW'(WORD_W - 1)) || (bit_cnt_inc == len_q)) begin
            state_d = StHold;
          end else begin
            pos_d   = pos_q + 1'b1;
            state_d = StShiftHi;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      StHold: begin
        // Shifting stays frozen here until the output register can take the word.
        if (!word_valid_q || word_ready) begin
          word_data_d  = acc_q;
          word_valid_d = 1'b1;
          word_last_d  = (bit_cnt_q == len_q);
          acc_d        = '0;
          pos_d        = '0;
          div_d        = '0;
          state_d      = StShiftHi;
        end
      end
      StShiftHi: begin
        if (div_q == DivW'(DIV - 1)) begin
          div_d = '0;
          if (bit_cnt_q == len_q) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StShiftLo;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d     = (state_d != StIdle);
    sc_c_en_d  = (state_d == StCapture);
    sc_d_clk_d = (state_d == StShiftHi);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      len_q        <= '0;
      bit_cnt_q    <= '0;
      pos_q        <= '0;
      div_q        <= '0;
      tmo_q        <= '0;
      acc_q        <= '0;
      word_data_q  <= '0;
      word_valid_q <= 1'b0;
      word_last_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      sc_c_en_q    <= 1'b0;
      sc_d_clk_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      bit_cnt_q    <= bit_cnt_d;
      pos_q        <= pos_d;
      div_q        <= div_d;
      tmo_q        <= tmo_d;
      acc_q        <= acc_d;
      word_data_q  <= word_data_d;
      word_valid_q <= word_valid_d;
      word_last_q  <= word_last_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      sc_c_en_q    <= sc_c_en_d;
      sc_d_clk_q   <= sc_d_clk_d;
    end
  end

  // Recirculate so the chain contents survive the readout.
  assign sc_d_in    = sc_d_out;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign sc_c_en    = sc_c_en_q;
  assign sc_d_clk   = sc_d_clk_q;
  assign word_data  = word_data_q;
  assign word_valid = word_valid_q;
  assign word_last  = word_last_q;

endmodule
